// File: rtl/resp_framer_pkg.sv
// Shared response codes, FSM encodings and message-size helper for the response framer.
package resp_framer_pkg;

  localparam logic [3:0] RESP_HIT      = 4'h1;
  localparam logic [3:0] RESP_FINISHED = 4'h2;
  localparam logic [3:0] RESP_PING     = 4'h3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    SEL_HIT  = 3'd1,
    SEL_FWD  = 3'd2,
    SEL_FIN  = 3'd3,
    SEL_PING = 3'd4
  } sel_e;

  function automatic int msg_bits(input int dev_w, input int src_w, input int payload_w);
    return 4 + dev_w + src_w + payload_w;
  endfunction

endpackage

// File: rtl/resp_framer_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] grant,
  output logic [SRC_W-1:0]   grant_idx,
  output logic               any
);

  // Scan from ptr upward; the first set request wins.
  always_comb begin
    int         cand_s;
    logic [SRC_W-1:0] cand_idx_s;
    logic       take_s;
    grant      = {NUM_SRC{1'b0}};
    grant_idx  = {SRC_W{1'b0}};
    any        = 1'b0;
    cand_s     = 0;
    cand_idx_s = {SRC_W{1'b0}};
    take_s     = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand_s            = (int'(ptr) + i) % NUM_SRC;
      cand_idx_s        = SRC_W'(cand_s);
      take_s            = !any && req[cand_idx_s];
      grant[cand_idx_s] = grant[cand_idx_s] | take_s;
      grant_idx         = take_s ? cand_idx_s : grant_idx;
      any               = any | take_s;
    end
  end

endmodule

// File: rtl/resp_framer.sv
// Response framer: arbitrates hits, forwarded chain traffic, finished and ping
// into fixed-length messages and serialises them LSB-byte-first to the UART.
module resp_framer
  import resp_framer_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int SRC_W        = 2,
  parameter int DEV_W        = 2,
  parameter int PAYLOAD_W    = 48,
  parameter int MSG_BYTES    = 7,
  parameter int MAX_CONSEC   = 8,
  parameter int DRAIN_CYCLES = 128,
  parameter int PING_LOG2    = 28
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic [DEV_W-1:0]               dev_id,
  input  logic [NUM_SRC-1:0]             hit_valid,
  input  logic [NUM_SRC*PAYLOAD_W-1:0]   hit_data,
  output logic [NUM_SRC-1:0]             hit_ack,
  input  logic                           fwd_valid,
  input  logic [8*MSG_BYTES-1:0]         fwd_msg,
  output logic                           fwd_ack,
  input  logic                           finished,
  input  logic [PAYLOAD_W-1:0]           ping_payload,
  output logic [7:0]                     tx_byte,
  output logic                           tx_req,
  input  logic                           tx_busy
);

  localparam int MSG_W   = 8 * MSG_BYTES;
  localparam int CNT_W   = $clog2(MSG_BYTES + 1);
  localparam int CONS_W  = $clog2(MAX_CONSEC + 1);
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  if (MSG_W != msg_bits(DEV_W, SRC_W, PAYLOAD_W)) begin : g_len_check
    $error("resp_framer: 8*MSG_BYTES must equal 4+DEV_W+SRC_W+PAYLOAD_W");
  end

  logic [0:0]           state_r;
  logic [MSG_W-1:0]     sr_r;
  logic [CNT_W-1:0]     byte_cnt_r;
  logic [SRC_W-1:0]     rr_ptr_r;
  logic [CONS_W-1:0]    consec_r;
  logic [DRAIN_W-1:0]   drain_r;
  logic                 sent_finished_r;
  logic [PING_LOG2-1:0] ping_cnt_r;
  logic                 ping_pending_r;

  logic [NUM_SRC-1:0]   grant_s;
  logic [SRC_W-1:0]     grant_idx_s;
  logic [SRC_W-1:0]     next_ptr_s;
  logic                 hit_any_s;
  logic                 hit_ok_s;
  logic                 finish_ready_s;
  sel_e                 sel_s;
  logic [MSG_W-1:0]     msg_s;

  rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_arb (
    .req       (hit_valid),
    .ptr       (rr_ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .any       (hit_any_s)
  );

  // Hits yield to pending forwarded traffic once MAX_CONSEC hits went out in a row.
  assign hit_ok_s       = hit_any_s && ((consec_r < CONS_W'(MAX_CONSEC)) || !fwd_valid);
  assign finish_ready_s = finished && (drain_r == {DRAIN_W{1'b0}});
  assign next_ptr_s     = (grant_idx_s == SRC_W'(NUM_SRC - 1)) ? {SRC_W{1'b0}} : grant_idx_s + SRC_W'(1);

  // Priority selection and message assembly for the idle state.
  always_comb begin
    sel_s = SEL_NONE;
    msg_s = {MSG_W{1'b0}};
    if ((state_r == ST_IDLE) && enable) begin
      if (hit_ok_s) begin
        sel_s = SEL_HIT;
        msg_s = {RESP_HIT, dev_id, grant_idx_s, hit_data[grant_idx_s*PAYLOAD_W +: PAYLOAD_W]};
      end else if (fwd_valid) begin
        sel_s = SEL_FWD;
        msg_s = fwd_msg;
      end else if (finish_ready_s && !sent_finished_r) begin
        sel_s = SEL_FIN;
        msg_s = {RESP_FINISHED, dev_id, {SRC_W{1'b0}}, {PAYLOAD_W{1'b0}}};
      end else if (ping_pending_r) begin
        sel_s = SEL_PING;
        msg_s = {RESP_PING, dev_id, {SRC_W{1'b0}}, ping_payload};
      end else begin
        sel_s = SEL_NONE;
      end
    end else begin
      sel_s = SEL_NONE;
    end
  end

  // Framing FSM: latch on selection, then emit one byte per free UART slot.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      sr_r       <= {MSG_W{1'b0}};
      byte_cnt_r <= {CNT_W{1'b0}};
      rr_ptr_r   <= {SRC_W{1'b0}};
      consec_r   <= {CONS_W{1'b0}};
      tx_req     <= 1'b0;
      tx_byte    <= 8'h00;
      hit_ack    <= {NUM_SRC{1'b0}};
      fwd_ack    <= 1'b0;
    end else begin
      tx_req  <= 1'b0;
      hit_ack <= {NUM_SRC{1'b0}};
      fwd_ack <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (sel_s == SEL_HIT) begin
            hit_ack  <= grant_s;
            rr_ptr_r <= next_ptr_s;
            if (consec_r < CONS_W'(MAX_CONSEC)) begin
              consec_r <= consec_r + CONS_W'(1);
            end
          end else begin
            consec_r <= {CONS_W{1'b0}};
          end
          if (sel_s == SEL_FWD) begin
            fwd_ack <= 1'b1;
          end
          if (sel_s != SEL_NONE) begin
            sr_r       <= msg_s;
            byte_cnt_r <= CNT_W'(MSG_BYTES);
            state_r    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!tx_busy && !tx_req) begin
            tx_req     <= 1'b1;
            tx_byte    <= sr_r[7:0];
            sr_r       <= {8'h00, sr_r[MSG_W-1:8]};
            byte_cnt_r <= byte_cnt_r - CNT_W'(1);
            if (byte_cnt_r == CNT_W'(1)) begin
              state_r <= ST_IDLE;
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Drain timer and one-shot finished flag; both rearm while the device is disabled.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      drain_r         <= DRAIN_W'(DRAIN_CYCLES);
      sent_finished_r <= 1'b0;
    end else if (!enable) begin
      drain_r         <= DRAIN_W'(DRAIN_CYCLES);
      sent_finished_r <= 1'b0;
    end else begin
      if (finished && (drain_r != {DRAIN_W{1'b0}})) begin
        drain_r <= drain_r - DRAIN_W'(1);
      end
      if (sel_s == SEL_FIN) begin
        sent_finished_r <= 1'b1;
      end
    end
  end

  // Free-running ping timer; a wrap coinciding with a ping send keeps it pending.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ping_cnt_r     <= {PING_LOG2{1'b0}};
      ping_pending_r <= 1'b0;
    end else begin
      ping_cnt_r <= ping_cnt_r + PING_LOG2'(1);
      if (ping_cnt_r == {PING_LOG2{1'b1}}) begin
        ping_pending_r <= 1'b1;
      end else if (sel_s == SEL_PING) begin
        ping_pending_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_resp_framer.sv
// Directed self-checking bench for resp_framer with small drain/ping parameters.
module tb_resp_framer;
  import resp_framer_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         enable;
  logic [1:0]   dev_id;
  logic [3:0]   hit_valid;
  logic [191:0] hit_data;
  logic [3:0]   hit_ack;
  logic         fwd_valid;
  logic [55:0]  fwd_msg;
  logic         fwd_ack;
  logic         finished;
  logic [47:0]  ping_payload;
  logic [7:0]   tx_byte;
  logic         tx_req;
  logic         tx_busy;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [7:0] byte_q[$];
  int         bcyc_q[$];
  logic [3:0] ack_q[$];

  resp_framer #(
    .NUM_SRC(4), .SRC_W(2), .DEV_W(2), .PAYLOAD_W(48), .MSG_BYTES(7),
    .MAX_CONSEC(8), .DRAIN_CYCLES(8), .PING_LOG2(6)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .dev_id(dev_id),
    .hit_valid(hit_valid), .hit_data(hit_data), .hit_ack(hit_ack),
    .fwd_valid(fwd_valid), .fwd_msg(fwd_msg), .fwd_ack(fwd_ack),
    .finished(finished), .ping_payload(ping_payload),
    .tx_byte(tx_byte), .tx_req(tx_req), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_req === 1'b1) begin
      byte_q.push_back(tx_byte);
      bcyc_q.push_back(cyc);
    end
    if (hit_ack !== 4'b0000) ack_q.push_back(hit_ack);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [55:0] msg_at(input int b);
    logic [55:0] m;
    m = 56'h0;
    for (int k = 0; k < 7; k++) m[8*k +: 8] = byte_q[b+k];
    return m;
  endfunction

  function automatic int count_code(input int b0, input logic [3:0] code);
    int n;
    logic [55:0] m;
    n = 0;
    for (int i = b0; i + 7 <= byte_q.size(); i += 7) begin
      m = msg_at(i);
      if (m[55:52] == code) n++;
    end
    return n;
  endfunction

  function automatic int first_code_cyc(input int b0, input logic [3:0] code);
    logic [55:0] m;
    for (int i = b0; i + 7 <= byte_q.size(); i += 7) begin
      m = msg_at(i);
      if (m[55:52] == code) return bcyc_q[i];
    end
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; enable = 1'b0; hit_valid = 4'b0000; fwd_valid = 1'b0;
    finished = 1'b0; tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1; enable = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) tick();
    n_cmp++; if (tx_req !== 1'b0) begin n_fail++; $display("FAIL reset_tx_req: got %b want 0", tx_req); end
    n_cmp++; if (tx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_tx_byte: got %h want 00", tx_byte); end
    n_cmp++; if (hit_ack !== 4'b0000) begin n_fail++; $display("FAIL reset_hit_ack: got %b want 0000", hit_ack); end
    n_cmp++; if (fwd_ack !== 1'b0) begin n_fail++; $display("FAIL reset_fwd_ack: got %b want 0", fwd_ack); end
    n_cmp++; if (dut.state_r !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %b want IDLE", dut.state_r); end
  endtask

  task automatic test_single_hit();
    logic [7:0] exp_b [7];
    int bb, ab;
    bit found;
    exp_b = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h00, 8'h00, 8'h16};
    do_reset();
    bb = byte_q.size(); ab = ack_q.size();
    hit_data[2*48 +: 48] = 48'h0000_1234_5678;
    hit_valid = 4'b0100;
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin tick(); if (hit_ack !== 4'b0000) found = 1'b1; end
    n_cmp++;
    if (!found) begin n_fail++; $display("FAIL single_ack: got no ack want 0100"); end
    else if (hit_ack !== 4'b0100) begin n_fail++; $display("FAIL single_ack: got %b want 0100", hit_ack); end
    hit_valid = 4'b0000;
    tick();
    n_cmp++; if (hit_ack !== 4'b0000) begin n_fail++; $display("FAIL single_ack_width: got %b want 0000", hit_ack); end
    n_cmp++; if (tx_req !== 1'b1) begin n_fail++; $display("FAIL single_first_req_latency: got %b want 1", tx_req); end
    for (int t = 0; t < 40 && byte_q.size() < bb + 7; t++) tick();
    n_cmp++;
    if (byte_q.size() < bb + 7) begin n_fail++; $display("FAIL single_bytes_timeout: got %0d want 7", byte_q.size() - bb); end
    else begin
      for (int k = 0; k < 7; k++) begin
        n_cmp++;
        if (byte_q[bb+k] !== exp_b[k]) begin n_fail++; $display("FAIL single_byte%0d: got %h want %h", k, byte_q[bb+k], exp_b[k]); end
      end
    end
    n_cmp++; if (ack_q.size() - ab != 1) begin n_fail++; $display("FAIL single_ack_count: got %0d want 1", ack_q.size() - ab); end
  endtask

  task automatic test_tx_busy();
    int bb;
    do_reset();
    bb = byte_q.size();
    tx_busy = 1'b1;
    hit_data[1*48 +: 48] = 48'h0000_0000_00C3;
    hit_valid = 4'b0010;
    for (int t = 0; t < 10 && hit_ack === 4'b0000; t++) tick();
    hit_valid = 4'b0000;
    repeat (10) tick();
    n_cmp++; if (byte_q.size() != bb) begin n_fail++; $display("FAIL busy_hold: got %0d bytes want 0", byte_q.size() - bb); end
    tx_busy = 1'b0;
    for (int t = 0; t < 40 && byte_q.size() < bb + 7; t++) tick();
    n_cmp++;
    if (byte_q.size() < bb + 7) begin n_fail++; $display("FAIL busy_resume_timeout: got %0d want 7", byte_q.size() - bb); end
    else if (msg_at(bb) !== {RESP_HIT, 2'b01, 2'b01, 48'h0000_0000_00C3}) begin
      n_fail++; $display("FAIL busy_msg: got %h want %h", msg_at(bb), {RESP_HIT, 2'b01, 2'b01, 48'h0000_0000_00C3});
    end
  endtask

  task automatic test_round_robin();
    int bb, ab;
    logic [3:0]  exp_a;
    logic [55:0] exp_m;
    logic [1:0]  s2;
    do_reset();
    bb = byte_q.size(); ab = ack_q.size();
    for (int s = 0; s < 4; s++) hit_data[s*48 +: 48] = 48'h0000_0000_00A0 + 48'(s);
    hit_valid = 4'b1111;
    for (int t = 0; t < 200 && ack_q.size() < ab + 5; t++) tick();
    hit_valid = 4'b0000;
    n_cmp++;
    if (ack_q.size() < ab + 5) begin n_fail++; $display("FAIL rr_timeout: got %0d acks want 5", ack_q.size() - ab); end
    else begin
      for (int k = 0; k < 5; k++) begin
        exp_a = 4'b0001 << (k % 4);
        n_cmp++;
        if (ack_q[ab+k] !== exp_a) begin n_fail++; $display("FAIL rr_grant%0d: got %b want %b", k, ack_q[ab+k], exp_a); end
      end
    end
    for (int t = 0; t < 60 && byte_q.size() < bb + 35; t++) tick();
    for (int k = 0; k < 4; k++) begin
      s2 = 2'(k);
      exp_m = {RESP_HIT, 2'b01, s2, 48'h0000_0000_00A0 + 48'(k)};
      n_cmp++;
      if (byte_q.size() < bb + 7*(k+1)) begin n_fail++; $display("FAIL rr_msg%0d: got missing want %h", k, exp_m); end
      else if (msg_at(bb + 7*k) !== exp_m) begin n_fail++; $display("FAIL rr_msg%0d: got %h want %h", k, msg_at(bb + 7*k), exp_m); end
    end
  endtask

  task automatic test_anti_starvation();
    int bb, ab;
    bit found;
    do_reset();
    bb = byte_q.size(); ab = ack_q.size();
    for (int s = 0; s < 4; s++) hit_data[s*48 +: 48] = 48'h0000_0000_00B0 + 48'(s);
    fwd_msg = 56'hF1_E2D3_C4B5_A697;
    hit_valid = 4'b1111;
    fwd_valid = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 300 && !found; t++) begin tick(); if (fwd_ack === 1'b1) found = 1'b1; end
    hit_valid = 4'b0000;
    fwd_valid = 1'b0;
    n_cmp++;
    if (!found) begin n_fail++; $display("FAIL starve_fwd_ack: got none want pulse"); end
    else if (ack_q.size() - ab != 8) begin n_fail++; $display("FAIL starve_hits_before_fwd: got %0d want 8", ack_q.size() - ab); end
    for (int t = 0; t < 60 && byte_q.size() < bb + 63; t++) tick();
    n_cmp++;
    if (byte_q.size() < bb + 63) begin n_fail++; $display("FAIL starve_fwd_msg: got missing want %h", fwd_msg); end
    else if (msg_at(bb + 56) !== fwd_msg) begin n_fail++; $display("FAIL starve_fwd_msg: got %h want %h", msg_at(bb + 56), fwd_msg); end
    n_cmp++; if (count_code(bb, RESP_HIT) < 8) begin n_fail++; $display("FAIL starve_hit_msgs: got %0d want 8", count_code(bb, RESP_HIT)); end
  endtask

  task automatic test_finished();
    int bb, rise, start;
    do_reset();
    bb = byte_q.size();
    tick();
    finished = 1'b1;
    rise = cyc;
    for (int t = 0; t < 80 && count_code(bb, RESP_FINISHED) < 1; t++) tick();
    start = first_code_cyc(bb, RESP_FINISHED);
    n_cmp++;
    if (start < 0) begin n_fail++; $display("FAIL fin_timeout: got none want finished msg"); end
    else if (start - rise < 8) begin n_fail++; $display("FAIL fin_drain: got %0d cycles want >=8", start - rise); end
    repeat (40) tick();
    n_cmp++; if (count_code(bb, RESP_FINISHED) != 1) begin n_fail++; $display("FAIL fin_once: got %0d want 1", count_code(bb, RESP_FINISHED)); end
    n_cmp++;
    if (count_code(bb, RESP_FINISHED) >= 1 && msg_at(bb + 7*0) !== {RESP_FINISHED, 2'b01, 2'b00, 48'h0}) begin
      n_fail++; $display("FAIL fin_msg: got %h want %h", msg_at(bb), {RESP_FINISHED, 2'b01, 2'b00, 48'h0});
    end
    enable = 1'b0;
    repeat (2) tick();
    enable = 1'b1;
    for (int t = 0; t < 80 && count_code(bb, RESP_FINISHED) < 2; t++) tick();
    repeat (40) tick();
    n_cmp++; if (count_code(bb, RESP_FINISHED) != 2) begin n_fail++; $display("FAIL fin_rearm: got %0d want 2", count_code(bb, RESP_FINISHED)); end
    finished = 1'b0;
  endtask

  task automatic test_ping_in_send();
    int bb;
    bit found;
    do_reset();
    bb = byte_q.size();
    repeat (55) tick();
    hit_data[0 +: 48] = 48'h0000_0000_0BAD;
    hit_valid = 4'b0001;
    for (int t = 0; t < 5 && hit_ack === 4'b0000; t++) tick();
    hit_valid = 4'b0000;
    found = 1'b0;
    for (int t = 0; t < 30 && !found; t++) begin tick(); if (dut.ping_pending_r === 1'b1) found = 1'b1; end
    n_cmp++;
    if (!found) begin n_fail++; $display("FAIL ping_pending_set: got 0 want 1"); end
    else if (dut.state_r !== ST_SEND) begin n_fail++; $display("FAIL ping_wrap_in_send: got state %b want SEND", dut.state_r); end
    for (int t = 0; t < 60 && byte_q.size() < bb + 14; t++) tick();
    n_cmp++;
    if (byte_q.size() < bb + 14) begin n_fail++; $display("FAIL ping_msg: got missing want ping"); end
    else begin
      if (msg_at(bb + 7) !== {RESP_PING, 2'b01, 2'b00, ping_payload}) begin
        n_fail++; $display("FAIL ping_msg: got %h want %h", msg_at(bb + 7), {RESP_PING, 2'b01, 2'b00, ping_payload});
      end
      n_cmp++;
      if (bcyc_q[bb+7] - bcyc_q[bb] != 14) begin n_fail++; $display("FAIL ping_follows_frame: got %0d want 14", bcyc_q[bb+7] - bcyc_q[bb]); end
    end
    tick();
    n_cmp++; if (dut.ping_pending_r !== 1'b0) begin n_fail++; $display("FAIL ping_cleared: got %b want 0", dut.ping_pending_r); end
  endtask

  task automatic test_reset_mid_frame();
    int bb, ab;
    do_reset();
    bb = byte_q.size(); ab = ack_q.size();
    hit_data[3*48 +: 48] = 48'h6655_4433_2211;
    hit_valid = 4'b1000;
    for (int t = 0; t < 10 && hit_ack === 4'b0000; t++) tick();
    hit_valid = 4'b0000;
    for (int t = 0; t < 20 && byte_q.size() < bb + 3; t++) tick();
    reset_n = 1'b0;
    tick();
    n_cmp++; if (tx_req !== 1'b0) begin n_fail++; $display("FAIL midrst_tx_req: got %b want 0", tx_req); end
    n_cmp++; if (dut.state_r !== ST_IDLE) begin n_fail++; $display("FAIL midrst_state: got %b want IDLE", dut.state_r); end
    tick();
    reset_n = 1'b1;
    repeat (30) tick();
    n_cmp++; if (byte_q.size() - bb != 3) begin n_fail++; $display("FAIL midrst_bytes: got %0d want 3", byte_q.size() - bb); end
    n_cmp++; if (ack_q.size() - ab != 1) begin n_fail++; $display("FAIL midrst_acks: got %0d want 1", ack_q.size() - ab); end
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; dev_id = 2'b01; hit_valid = 4'b0000;
    hit_data = 192'h0; fwd_valid = 1'b0; fwd_msg = 56'h0; finished = 1'b0;
    ping_payload = 48'hABCD_EF01_2345; tx_busy = 1'b0;
    test_reset();
    test_single_hit();
    test_tx_busy();
    test_round_robin();
    test_anti_starvation();
    test_finished();
    test_ping_in_send();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
